// File: rtl/uart_bus_master.sv
// UART-driven single-word bus initiator: 'W'/'R' command frames in on uart_rx,
// one MMIO bus cycle per command, ACK/NAK or read data back on uart_tx.
module uart_bus_master #(
  parameter int         CLK_DIV  = 16,
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, REQ, BUS_WR, BUS_RD, BUS_CAP, SEND} state_t;

  // receiver
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_s, rx_valid, rx_ferr;

  // command engine
  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;

  // transmitter
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_active_q, tx_active_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [23:0]   tx_buf_q, tx_buf_d;
  logic [1:0]    tx_left_q, tx_left_d;
  logic          tx_load;
  logic [31:0]   tx_load_data;
  logic [1:0]    tx_load_left;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], uart_rx};
    rx_prev_d  = rx_s;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        // a start bit that is high again at mid-bit was line noise
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_FULL) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_FULL) begin
          rx_cnt_d   = '0;
          rx_valid   = rx_s;
          rx_ferr    = !rx_s;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tx_load      = 1'b0;
    tx_load_data = {24'h0, NAK_BYTE};
    tx_load_left = 2'd0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          byte_cnt_d = 2'd0;
          if (rx_shift_q == 8'h57) begin
            is_wr_d = 1'b1;
            state_d = GET_ADDR;
          end else if (rx_shift_q == 8'h52) begin
            is_wr_d = 1'b0;
            state_d = GET_ADDR;
          end else begin
            tx_load = 1'b1;
          end
        end else if (rx_ferr) begin
          tx_load = 1'b1;
        end
      end
      GET_ADDR, GET_DATA: begin
        if (rx_ferr) begin
          tx_load = 1'b1;
          state_d = IDLE;
        end else if (rx_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == GET_ADDR) addr_d = {rx_shift_q, addr_q[31:8]};
          else                     data_d = {rx_shift_q, data_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == GET_ADDR && is_wr_q) state_d = GET_DATA;
            else                                state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_gnt) state_d = is_wr_q ? BUS_WR : BUS_RD;
      end
      BUS_WR: begin
        tx_load      = 1'b1;
        tx_load_data = {24'h0, ACK_BYTE};
        state_d      = SEND;
      end
      BUS_RD: state_d = BUS_CAP;
      BUS_CAP: begin
        tx_load      = 1'b1;
        tx_load_data = memReadData;
        tx_load_left = 2'd3;
        state_d      = SEND;
      end
      SEND: begin
        if (!tx_active_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // frames are reloaded straight after the stop bit, so queued bytes leave back-to-back
  always_comb begin
    tx_shift_d  = tx_shift_q;
    tx_active_d = tx_active_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_buf_d    = tx_buf_q;
    tx_left_d   = tx_left_q;
    if (tx_load) begin
      tx_shift_d  = {1'b1, tx_load_data[7:0], 1'b0};
      tx_buf_d    = tx_load_data[31:8];
      tx_left_d   = tx_load_left;
      tx_active_d = 1'b1;
      tx_cnt_d    = '0;
      tx_bit_d    = 4'd0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == CNT_FULL) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          if (tx_left_q != 2'd0) begin
            tx_shift_d = {1'b1, tx_buf_q[7:0], 1'b0};
            tx_buf_d   = {8'h00, tx_buf_q[23:8]};
            tx_left_d  = tx_left_q - 2'd1;
            tx_bit_d   = 4'd0;
          end else begin
            tx_active_d = 1'b0;
          end
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_sync_q   <= '0;
      rx_prev_q   <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_shift_q  <= '1;
      tx_active_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_buf_q    <= '0;
      tx_left_q   <= '0;
    end else begin
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_shift_q  <= tx_shift_d;
      tx_active_q <= tx_active_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_buf_q    <= tx_buf_d;
      tx_left_q   <= tx_left_d;
    end
  end

  // bus outputs stay zero outside the bus cycle so masters can be OR-combined
  always_comb begin
    bus_req      = (state_q == REQ) || (state_q == BUS_WR) ||
                   (state_q == BUS_RD) || (state_q == BUS_CAP);
    memAddress   = ((state_q == BUS_WR) || (state_q == BUS_RD)) ? addr_q : 32'h0;
    memWriteData = (state_q == BUS_WR) ? data_q : 32'h0;
    byteMask     = (state_q == BUS_WR) ? 4'hF : 4'h0;
    memWrite     = (state_q == BUS_WR);
  end

  assign uart_tx = tx_shift_q[0];

endmodule
